// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: initiator side of the multi-cycle MUL/DIV/REM start/done
// interface. Latches one request, pulses alu_start, waits for alu_done under a
// watchdog and hands the result to writeback over a valid/ready handshake.
// Optional build macro MULDIV_RESULT_CACHE_EN adds a one-entry result cache
// that short-circuits a repeated {code, op1, op2} straight to the response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a request; busy low
//   S_START | one-cycle alu_start strobe; watchdog cleared; done ignored
//   S_WAIT  | waiting for alu_done or watchdog expiry
//   S_RESP  | wb_valid high, result held until wb_ready or flush
//   S_DRAIN | op killed by flush; wait out done/timeout, no writeback
module muldiv_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_alucode,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        alu_start,
  output logic [5:0]  alu_code,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // The counter holds (WAIT/DRAIN cycles elapsed - 1), so it expires on the
  // TIMEOUT_CYCLES-th cycle after START.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wd_cnt;
  logic              wd_expire;
  logic              accept;
  logic              cache_hit;
  logic [31:0]       hit_data;

  assign wd_expire = (wd_cnt >= WD_LAST);
  assign accept    = req_valid && (state == S_IDLE) && !flush;

`ifdef MULDIV_RESULT_CACHE_EN
  logic        cache_vld;
  logic [5:0]  cache_code;
  logic [31:0] cache_op1;
  logic [31:0] cache_op2;
  logic [31:0] cache_res;

  assign cache_hit = cache_vld && (cache_code == req_alucode) &&
                     (cache_op1 == req_op1) && (cache_op2 == req_op2);
  assign hit_data  = cache_res;

  // Cache: refreshed on every good completion, dropped on timeout; flush-killed ops never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld  <= 1'b0;
      cache_code <= '0;
      cache_op1  <= '0;
      cache_op2  <= '0;
      cache_res  <= '0;
    end else if (state == S_WAIT && !flush) begin
      if (alu_done) begin
        cache_vld  <= 1'b1;
        cache_code <= alu_code;
        cache_op1  <= alu_op1;
        cache_op2  <= alu_op2;
        cache_res  <= alu_result;
      end else if (wd_expire) begin
        cache_vld  <= 1'b0;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: flush outranks accept, done and wb_ready in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = cache_hit ? S_RESP : S_START;
      S_START: state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)                       state_nxt = S_DRAIN;
        else if (alu_done || wd_expire)  state_nxt = S_RESP;
      end
      S_RESP:  if (flush || wb_ready) state_nxt = S_IDLE;
      S_DRAIN: if (alu_done || wd_expire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready also masks a same-cycle flush.
  always_comb begin
    req_ready = 1'b0;
    alu_start = 1'b0;
    wb_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = !flush;
        busy      = 1'b0;
      end
      S_START: alu_start = 1'b1;
      S_RESP:  wb_valid  = 1'b1;
      default: ;
    endcase
  end

  // Watchdog: cleared in START, counts through WAIT and DRAIN, saturates at expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if ((state == S_WAIT || state == S_DRAIN) && !wd_expire) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // Operand/rd latch on accept and result capture on completion or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_code <= '0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
    end else begin
      if (accept) begin
        alu_code <= req_alucode;
        alu_op1  <= req_op1;
        alu_op2  <= req_op2;
        wb_rd    <= req_rd;
      end
      if (accept && cache_hit) begin
        wb_data <= hit_data;
        wb_err  <= 1'b0;
      end else if (state == S_WAIT && !flush) begin
        if (alu_done) begin
          wb_data <= alu_result;
          wb_err  <= 1'b0;
        end else if (wd_expire) begin
          wb_data <= '0;
          wb_err  <= 1'b1;
        end
      end
    end
  end

endmodule
